// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry and FSM encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: centre-sampled start/data/stop bits on an oversample enable,
// one-clock valid or frame-error pulse per frame, break hold-off after a bad stop bit.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_error
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [BIT_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt;
    logic                 frame_error_nxt;
    logic                 rx_busy_nxt;
    logic                 rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shreg       <= shreg_nxt;
            rx_data     <= rx_data_nxt;
            rx_valid    <= rx_valid_nxt;
            frame_error <= frame_error_nxt;
            rx_busy     <= rx_busy_nxt;
        end
    end

    // Next-state logic; everything advances only on sample_tick except the pulses.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        bit_idx_nxt     = bit_idx;
        shreg_nxt       = shreg;
        rx_data_nxt     = rx_data;
        rx_valid_nxt    = 1'b0;
        frame_error_nxt = 1'b0;

        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        cnt_nxt   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(OVERSAMPLE / 2 - 1)) begin
                        cnt_nxt     = '0;
                        bit_idx_nxt = '0;
                        state_nxt   = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
                        shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
                        cnt_nxt     = '0;
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leave at stop-bit centre so a back-to-back start edge is not missed.
                    if (cnt == CNT_W'(OVERSAMPLE - 1)) begin
                        cnt_nxt = '0;
                        if (rx_s) begin
                            rx_data_nxt  = shreg;
                            rx_valid_nxt = 1'b1;
                            state_nxt    = IDLE;
                        end else begin
                            frame_error_nxt = 1'b1;
                            state_nxt       = BREAK;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        rx_busy_nxt = (state_nxt != IDLE);
    end

endmodule
